// File: rtl/f3_pkg.sv
// Shared GF(3) definitions: op codes, digit constants, sequencer states and
// the rule that maps the illegal 2'b11 digit onto zero.
package f3_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'd0,
      OP_SUB  = 2'd1,
      OP_MULT = 2'd2,
      OP_DOT  = 2'd3
   } op_t;

   localparam logic [1:0] F3_ZERO = 2'b00;
   localparam logic [1:0] F3_ONE  = 2'b01;
   localparam logic [1:0] F3_TWO  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   function automatic logic [1:0] f3_clean(input logic [1:0] d);
      return (d == 2'b11) ? F3_ZERO : d;
   endfunction

endpackage

// File: rtl/f3_vec_seq_if.sv
// Request/result bundle between a field-level controller and f3_vec_seq.
interface f3_vec_seq_if #(
   parameter int M = 97
);
   logic           start;
   logic [1:0]     op;
   logic [2*M-1:0] a;
   logic [2*M-1:0] b;
   logic           busy;
   logic           done;
   logic [2*M-1:0] c;
   logic           err;

   modport master (output start, op, a, b, input busy, done, c, err);
   modport slave  (input start, op, a, b, output busy, done, c, err);
endinterface

// File: rtl/f3_add.sv
// GF(3) digit adder; operands are assumed legal (0, 1 or 2).
module f3_add (
   input  logic [1:0] x,
   input  logic [1:0] y,
   output logic [1:0] s
);
   logic [2:0] sum;

   assign sum = {1'b0, x} + {1'b0, y};
   assign s   = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
endmodule

// File: rtl/f3_alu.sv
// Shared digit ALU: one adder and one multiplier. In DOT mode the adder folds
// the product into the running accumulator instead of adding a and b.
module f3_alu
   import f3_pkg::*;
(
   input  op_t        op,
   input  logic [1:0] a_dig,
   input  logic [1:0] b_dig,
   input  logic [1:0] acc,
   output logic [1:0] r
);
   logic [1:0] prod;
   logic [1:0] add_x;
   logic [1:0] add_y;
   logic [1:0] sum;

   f3_mult u_mult (.x(a_dig), .y(b_dig), .p(prod));
   f3_add  u_add  (.x(add_x), .y(add_y), .s(sum));

   always_comb begin
      add_x = a_dig;
      add_y = b_dig;
      r     = sum;
      case (op)
         OP_SUB:  add_y = {b_dig[0], b_dig[1]};   // negation swaps hi/lo
         OP_MULT: r     = prod;
         OP_DOT: begin
            add_x = acc;
            add_y = prod;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/f3_mult.sv
// GF(3) digit multiplier; operands are assumed legal (0, 1 or 2).
module f3_mult
   import f3_pkg::*;
(
   input  logic [1:0] x,
   input  logic [1:0] y,
   output logic [1:0] p
);
   // Nonzero digits multiply to 1 when equal (1*1, 2*2) and to 2 otherwise.
   assign p = (x == F3_ZERO || y == F3_ZERO) ? F3_ZERO :
              (x == y)                       ? F3_ONE  : F3_TWO;
endmodule

// File: rtl/f3_vec_seq.sv
// Digit-serial GF(3)^M vector unit: one digit per clock through a shared ALU,
// result valid M+1 clocks after the accepted start.
module f3_vec_seq
   import f3_pkg::*;
#(
   parameter int M = 97
) (
   input  logic        clk,
   input  logic        reset_n,
   f3_vec_seq_if.slave bus
);
   localparam int W  = 2 * M;
   localparam int CW = $clog2(M);

   state_t         state_reg, state_next;
   logic [CW-1:0]  cnt_reg;
   logic [W-1:0]   a_sr_reg, b_sr_reg, c_reg;
   logic [W-3:0]   r_sr_reg;
   op_t            op_reg;
   logic [1:0]     acc_reg;
   logic           err_acc_reg, err_reg;

   logic           accept, last;
   logic           bad_dig;
   logic [1:0]     a_dig, b_dig, alu_r;

   assign accept  = bus.start && (state_reg != ST_RUN);
   assign last    = (cnt_reg == CW'(M - 1));
   assign bad_dig = (a_sr_reg[1:0] == 2'b11) || (b_sr_reg[1:0] == 2'b11);
   assign a_dig   = f3_clean(a_sr_reg[1:0]);
   assign b_dig   = f3_clean(b_sr_reg[1:0]);

   f3_alu u_alu (
      .op   (op_reg),
      .a_dig(a_dig),
      .b_dig(b_dig),
      .acc  (acc_reg),
      .r    (alu_r)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_reg <= ST_IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (bus.start) state_next = ST_RUN;
         ST_RUN:  if (last)      state_next = ST_DONE;
         ST_DONE: state_next = bus.start ? ST_RUN : ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_reg     <= '0;
         a_sr_reg    <= '0;
         b_sr_reg    <= '0;
         r_sr_reg    <= '0;
         c_reg       <= '0;
         op_reg      <= OP_ADD;
         acc_reg     <= F3_ZERO;
         err_acc_reg <= 1'b0;
         err_reg     <= 1'b0;
      end else if (accept) begin
         a_sr_reg    <= bus.a;
         b_sr_reg    <= bus.b;
         op_reg      <= op_t'(bus.op);
         cnt_reg     <= '0;
         acc_reg     <= F3_ZERO;
         err_acc_reg <= 1'b0;
      end else if (state_reg == ST_RUN) begin
         a_sr_reg    <= a_sr_reg >> 2;
         b_sr_reg    <= b_sr_reg >> 2;
         // Result register holds digits 0..M-2; the last digit comes straight from the ALU.
         r_sr_reg    <= (W-2)'({alu_r, r_sr_reg} >> 2);
         err_acc_reg <= err_acc_reg | bad_dig;
         cnt_reg     <= cnt_reg + CW'(1);
         if (op_reg == OP_DOT) acc_reg <= alu_r;
         if (last) begin
            c_reg   <= (op_reg == OP_DOT) ? W'(alu_r) : {alu_r, r_sr_reg};
            err_reg <= err_acc_reg | bad_dig;
         end
      end
   end

   assign bus.busy = (state_reg == ST_RUN);
   assign bus.done = (state_reg == ST_DONE);
   assign bus.c    = c_reg;
   assign bus.err  = err_reg;
endmodule

// File: tb/tb_f3_vec_seq.sv
// Bench for f3_vec_seq: M=4 and M=97 instances checked every cycle against a
// digit-arithmetic reference model, plus hand-computed directed vectors.
module tb_f3_vec_seq;
   localparam int MW = 194;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   f3_vec_seq_if #(.M(4))  bus4 ();
   f3_vec_seq_if #(.M(97)) bus97 ();

   f3_vec_seq #(.M(4))  dut4  (.clk(clk), .reset_n(reset_n), .bus(bus4));
   f3_vec_seq #(.M(97)) dut97 (.clk(clk), .reset_n(reset_n), .bus(bus97));

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   logic          st_in[2];
   logic [1:0]    op_in[2];
   logic [MW-1:0] a_in[2], b_in[2], c_out[2];
   logic          busy_out[2], done_out[2], err_out[2];

   assign st_in[0] = bus4.start;  assign st_in[1] = bus97.start;
   assign op_in[0] = bus4.op;     assign op_in[1] = bus97.op;
   assign a_in[0]  = {186'b0, bus4.a}; assign a_in[1] = bus97.a;
   assign b_in[0]  = {186'b0, bus4.b}; assign b_in[1] = bus97.b;
   assign c_out[0] = {186'b0, bus4.c}; assign c_out[1] = bus97.c;
   assign busy_out[0] = bus4.busy; assign busy_out[1] = bus97.busy;
   assign done_out[0] = bus4.done; assign done_out[1] = bus97.done;
   assign err_out[0]  = bus4.err;  assign err_out[1]  = bus97.err;

   function automatic int m_of(int k);
      return (k == 0) ? 4 : 97;
   endfunction

   function automatic int dig(logic [MW-1:0] v, int i);
      logic [1:0] d;
      d = v[2*i +: 2];
      return (d == 2'b11) ? 0 : int'(d);
   endfunction

   function automatic logic [MW-1:0] ref_vec(int m, logic [1:0] op, logic [MW-1:0] a, logic [MW-1:0] b);
      logic [MW-1:0] r;
      int x, y, s;
      r = '0;
      s = 0;
      for (int i = 0; i < m; i++) begin
         x = dig(a, i);
         y = dig(b, i);
         case (op)
            2'd0:    r[2*i +: 2] = 2'((x + y) % 3);
            2'd1:    r[2*i +: 2] = 2'((x - y + 3) % 3);
            2'd2:    r[2*i +: 2] = 2'((x * y) % 3);
            default: s = s + x * y;
         endcase
      end
      if (op == 2'd3) r[1:0] = 2'(s % 3);
      return r;
   endfunction

   function automatic bit ref_err(int m, logic [MW-1:0] a, logic [MW-1:0] b);
      bit e;
      e = 1'b0;
      for (int i = 0; i < m; i++)
         if (a[2*i +: 2] == 2'b11 || b[2*i +: 2] == 2'b11) e = 1'b1;
      return e;
   endfunction

   // Model: an operation accepted while not busy completes after M busy cycles.
   int            run_left[2] = '{0, 0};
   bit            done_now[2] = '{0, 0};
   bit            pend_err[2], exp_err[2];
   logic [MW-1:0] pend_c[2], exp_c[2];

   always @(posedge clk or negedge reset_n) begin
      bit free_now;
      if (!reset_n) begin
         for (int k = 0; k < 2; k++) begin
            run_left[k] = 0;
            done_now[k] = 1'b0;
            exp_c[k]    = '0;
            exp_err[k]  = 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            free_now    = (run_left[k] == 0);
            done_now[k] = 1'b0;
            if (run_left[k] > 0) begin
               run_left[k]--;
               if (run_left[k] == 0) begin
                  done_now[k] = 1'b1;
                  exp_c[k]    = pend_c[k];
                  exp_err[k]  = pend_err[k];
               end
            end
            if (free_now && st_in[k]) begin
               run_left[k] = m_of(k);
               pend_c[k]   = ref_vec(m_of(k), op_in[k], a_in[k], b_in[k]);
               pend_err[k] = ref_err(m_of(k), a_in[k], b_in[k]);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            checks += 4;
            if (busy_out[k] !== (run_left[k] > 0)) begin
               errors++;
               $display("FAIL busy M=%0d t=%0t: got %0b want %0b", m_of(k), $time, busy_out[k], run_left[k] > 0);
            end
            if (done_out[k] !== done_now[k]) begin
               errors++;
               $display("FAIL done M=%0d t=%0t: got %0b want %0b", m_of(k), $time, done_out[k], done_now[k]);
            end
            if (c_out[k] !== exp_c[k]) begin
               errors++;
               $display("FAIL c M=%0d t=%0t: got %0h want %0h", m_of(k), $time, c_out[k], exp_c[k]);
            end
            if (err_out[k] !== exp_err[k]) begin
               errors++;
               $display("FAIL err M=%0d t=%0t: got %0b want %0b", m_of(k), $time, err_out[k], exp_err[k]);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [MW-1:0] got, input logic [MW-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end else begin
         $display("ok   %s = %0h", nm, got);
      end
   endtask

   task automatic op4(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] want_c, input bit want_err, input bit poke, input string nm);
      int lat;
      @(negedge clk);
      bus4.start = 1'b1; bus4.op = op; bus4.a = a; bus4.b = b;
      @(negedge clk);
      bus4.start = 1'b0;
      bus4.a  = 8'($urandom);
      bus4.b  = 8'($urandom);
      bus4.op = 2'($urandom);
      lat = 1;
      while (!bus4.done && lat < 20) begin
         @(negedge clk);
         lat++;
         bus4.start = poke && (lat == 2);
      end
      chk({nm, " latency"}, MW'(lat), MW'(5));
      chk({nm, " c"}, MW'(bus4.c), MW'(want_c));
      chk({nm, " err"}, MW'(bus4.err), MW'(want_err));
   endtask

   task automatic op97(input logic [1:0] op);
      logic [MW-1:0] va, vb;
      int lat;
      for (int i = 0; i < 97; i++) begin
         va[2*i +: 2] = ($urandom_range(0, 40) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         vb[2*i +: 2] = 2'($urandom_range(0, 2));
      end
      @(negedge clk);
      bus97.start = 1'b1; bus97.op = op; bus97.a = va; bus97.b = vb;
      @(negedge clk);
      bus97.start = 1'b0;
      bus97.a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      lat = 1;
      while (!bus97.done && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      chk($sformatf("M97 op%0d latency", op), MW'(lat), MW'(98));
      chk($sformatf("M97 op%0d c", op), bus97.c, ref_vec(97, op, va, vb));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ndone;
      bus4.start = 1'b0;  bus4.op = 2'd0;  bus4.a = '0;  bus4.b = '0;
      bus97.start = 1'b0; bus97.op = 2'd0; bus97.a = '0; bus97.b = '0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      reset_n = 1'b1;
      @(negedge clk);
      chk("reset busy", MW'(bus4.busy), MW'(0));
      chk("reset done", MW'(bus4.done), MW'(0));
      chk("reset c", MW'(bus4.c), MW'(0));
      chk("reset err", MW'(bus4.err), MW'(0));

      chk("model add",  ref_vec(4, 2'd0, MW'(8'h92), MW'(8'h5A)), MW'(8'h29));
      chk("model sub",  ref_vec(4, 2'd1, MW'(8'h92), MW'(8'h5A)), MW'(8'h44));
      chk("model mult", ref_vec(4, 2'd2, MW'(8'h92), MW'(8'h5A)), MW'(8'h91));
      chk("model dot",  ref_vec(4, 2'd3, MW'(8'h92), MW'(8'h5A)), MW'(8'h01));

      op4(2'd0, 8'h92, 8'h5A, 8'h29, 1'b0, 1'b0, "ADD");
      op4(2'd1, 8'h92, 8'h5A, 8'h44, 1'b0, 1'b0, "SUB");
      op4(2'd2, 8'h92, 8'h5A, 8'h91, 1'b0, 1'b0, "MULT");
      op4(2'd3, 8'h92, 8'h5A, 8'h01, 1'b0, 1'b0, "DOT");
      op4(2'd0, 8'h03, 8'h55, 8'h55, 1'b1, 1'b0, "ILLEGAL");
      op4(2'd0, 8'h92, 8'h5A, 8'h29, 1'b0, 1'b0, "CLEAN");
      op4(2'd1, 8'h92, 8'h5A, 8'h44, 1'b0, 1'b1, "POKE");

      // Continuous start: one result every M+1 cycles.
      @(negedge clk);
      bus4.start = 1'b1; bus4.op = 2'd0; bus4.a = 8'h92; bus4.b = 8'h5A;
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus4.done) ndone++;
      end
      bus4.start = 1'b0;
      chk("hold done count", MW'(ndone), MW'(3));

      // Abort mid-RUN with an asynchronous reset.
      @(negedge clk);
      bus4.start = 1'b1; bus4.op = 2'd2; bus4.a = 8'h92; bus4.b = 8'h5A;
      @(negedge clk);
      bus4.start = 1'b0;
      @(negedge clk);
      #1 reset_n = 1'b0;
      #1;
      chk("abort busy", MW'(bus4.busy), MW'(0));
      chk("abort done", MW'(bus4.done), MW'(0));
      chk("abort c", MW'(bus4.c), MW'(0));
      chk("abort err", MW'(bus4.err), MW'(0));
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      op4(2'd2, 8'h92, 8'h5A, 8'h91, 1'b0, 1'b0, "AFTER RESET");

      // Random traffic, including starts during RUN.
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         bus4.start = ($urandom_range(0, 2) == 0);
         bus4.op    = 2'($urandom);
         bus4.a     = 8'($urandom);
         bus4.b     = 8'($urandom);
      end
      bus4.start = 1'b0;
      repeat (8) @(negedge clk);

      for (int r = 0; r < 2; r++)
         for (int op = 0; op < 4; op++)
            op97(2'(op));
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
